// File: rtl/ysyx_22050854_div_pkg.sv
// Shared types and constants for the divider issue controller.
// The fast path is built only when YSYX_22050854_DIV_FASTPATH_EN is defined.
package ysyx_22050854_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } div_state_e;

  localparam logic [63:0] INT64_MIN  = 64'h8000_0000_0000_0000;
  localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
  localparam logic [63:0] ALL_ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  // Op kind, packed as {op_rem, op_unsigned, op_w}.
  typedef struct packed {
    logic rem;
    logic uns;
    logic w;
  } div_op_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22050854_div_special.sv
// Combinational resolver for divide-by-zero and signed overflow (RV64M results).
// Only instantiated when YSYX_22050854_DIV_FASTPATH_EN is defined.
module ysyx_22050854_div_special
  import ysyx_22050854_div_pkg::*;
(
  input  div_op_t     op,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic        is_special,
  output logic [63:0] special_res
);

  logic [63:0] a_ext;
  logic        div_zero;
  logic        ovf;

  always_comb begin
    a_ext    = op.w ? sext32(src1[31:0]) : src1;
    div_zero = op.w ? (src2[31:0] == 32'd0) : (src2 == 64'd0);
    ovf      = !op.uns && (op.w ? (src1[31:0] == INT32_MIN && src2[31:0] == 32'hFFFF_FFFF)
                                : (src1 == INT64_MIN && src2 == ALL_ONES64));
    is_special  = div_zero | ovf;
    special_res = 64'd0;
    if (div_zero) begin
      special_res = op.rem ? a_ext : ALL_ONES64;
    end else if (ovf) begin
      special_res = op.rem ? 64'd0 : a_ext;
    end
  end

endmodule

// File: rtl/ysyx_22050854_div_ctrl.sv
// Issue-side controller for the shared multi-cycle divider; stalls the pipe via busy.
// Define YSYX_22050854_DIV_FASTPATH_EN to resolve /0 and overflow without the divider.
module ysyx_22050854_div_ctrl
  import ysyx_22050854_div_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_rem,
  input  logic        op_unsigned,
  input  logic        op_w,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        busy,
  output logic        div_valid,
  output logic        divw,
  output logic        div_signed,
  output logic [63:0] dividend,
  output logic [63:0] divisor,
  input  logic        div_ready,
  input  logic        out_valid,
  input  logic [63:0] quotient,
  input  logic [63:0] remainder
);

  // Handshakes: a transfer happens on a rising clock edge where valid and ready
  // are both high; valid never depends combinationally on ready.

  div_state_e  state_q, state_d;
  div_op_t     op_q, op_d;
  logic [63:0] src1_q, src1_d;
  logic [63:0] src2_q, src2_d;
  logic [63:0] res_q, res_d;

  div_op_t     in_op;
  logic        accept;
  logic [63:0] sel_res;
  logic        is_special;
  logic [63:0] special_res;

  assign in_op  = '{rem: op_rem, uns: op_unsigned, w: op_w};
  assign accept = (state_q == ST_IDLE) && in_valid && !flush;

`ifdef YSYX_22050854_DIV_FASTPATH_EN
  ysyx_22050854_div_special u_special (
    .op          (in_op),
    .src1        (src1),
    .src2        (src2),
    .is_special  (is_special),
    .special_res (special_res)
  );
`else
  assign is_special  = 1'b0;
  assign special_res = 64'd0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      src1_q  <= 64'd0;
      src2_q  <= 64'd0;
      res_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      res_q   <= res_d;
    end
  end

  // Flush outranks every other event in every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = is_special ? ST_DONE : ST_ISSUE;
      ST_ISSUE: begin
        if (flush)          state_d = div_ready ? ST_DRAIN : ST_IDLE;
        else if (div_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush)          state_d = out_valid ? ST_IDLE : ST_DRAIN;
        else if (out_valid) state_d = ST_DONE;
      end
      ST_DONE:  if (flush || res_ready) state_d = ST_IDLE;
      ST_DRAIN: if (!flush && out_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The divider's upper half is never trusted for W ops.
  always_comb begin
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    res_d   = res_q;
    sel_res = op_q.rem ? remainder : quotient;
    if (accept) begin
      op_d   = in_op;
      src1_d = src1;
      src2_d = src2;
      if (is_special) res_d = special_res;
    end
    if ((state_q == ST_WAIT) && out_valid && !flush) begin
      res_d = op_q.w ? sext32(sel_res[31:0]) : sel_res;
    end
  end

  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    res_valid  = (state_q == ST_DONE);
    res_data   = res_q;
    div_valid  = (state_q == ST_ISSUE);
    divw       = op_q.w;
    div_signed = ~op_q.uns;
    dividend   = src1_q;
    divisor    = src2_q;
  end

endmodule

// File: tb/tb_ysyx_22050854_div_ctrl.sv
// Self-checking bench for ysyx_22050854_div_ctrl with a behavioural divider model.
// Honours YSYX_22050854_DIV_FASTPATH_EN for the fast-path-only expectations.
module tb_ysyx_22050854_div_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, op_rem = 1'b0, op_unsigned = 1'b0, op_w = 1'b0;
  logic        flush = 1'b0, res_ready = 1'b1, div_ready = 1'b1;
  logic [63:0] src1 = 64'd0, src2 = 64'd0;
  logic        in_ready, res_valid, busy, div_valid, divw, div_signed, out_valid;
  logic [63:0] res_data, dividend, divisor, quotient, remainder;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];
  int          lat = 3;
  int          accepts = 0;

  typedef struct {
    string       name;
    logic        rem;
    logic        uns;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  ysyx_22050854_div_ctrl dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_rem(op_rem), .op_unsigned(op_unsigned), .op_w(op_w),
    .src1(src1), .src2(src2), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
    .div_valid(div_valid), .divw(divw), .div_signed(div_signed),
    .dividend(dividend), .divisor(divisor), .div_ready(div_ready), .out_valid(out_valid),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clock = ~clock;

  // ---------------- divider model (garbage upper half on W ops) ----------------
  function automatic logic [127:0] ref_div(input logic w, input logic uns,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] q, r;
    logic [31:0] q32, r32;
    q = 64'd0; r = 64'd0; q32 = 32'd0; r32 = 32'd0;
    if (w) begin
      if (b[31:0] == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a[31:0];
      end else if (!uns && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        q32 = a[31:0]; r32 = 32'd0;
      end else if (uns) begin
        q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
      end else begin
        q32 = $signed(a[31:0]) / $signed(b[31:0]); r32 = $signed(a[31:0]) % $signed(b[31:0]);
      end
      q = {32'hDEAD_BEEF, q32}; r = {32'hDEAD_BEEF, r32};
    end else begin
      if (b == 64'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
      end else if (!uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a; r = 64'd0;
      end else if (uns) begin
        q = a / b; r = a % b;
      end else begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end
    end
    return {q, r};
  endfunction

  logic [127:0] calc, pend;
  int           cnt;
  assign calc = ref_div(divw, ~div_signed, dividend, divisor);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= 0; out_valid <= 1'b0; quotient <= 64'd0; remainder <= 64'd0; pend <= '0;
    end else begin
      out_valid <= 1'b0;
      if (div_valid && div_ready) begin
        pend <= calc; cnt <= lat; accepts <= accepts + 1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          out_valid <= 1'b1; quotient <= pend[127:64]; remainder <= pend[63:0];
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      check("in_ready_and_res_valid", {63'd0, in_ready & res_valid}, 64'd0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
        else check("res_data", res_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  function automatic vec_t mk(input string n, input logic rem, input logic uns, input logic w,
                              input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
    vec_t v;
    v.name = n; v.rem = rem; v.uns = uns; v.w = w; v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  task automatic drive_op(input vec_t v);
    op_rem = v.rem; op_unsigned = v.uns; op_w = v.w; src1 = v.a; src2 = v.b;
  endtask

  task automatic send(input vec_t v, input bit push);
    int n = 0;
    while (!in_ready && n < 300) begin @(posedge clock); #1; n++; end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    drive_op(v);
    in_valid = 1'b1;
    if (push) exp_q.push_back(v.exp);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 500) begin @(posedge clock); #1; n++; end
    if (exp_q.size() != 0 || !in_ready) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic wait_neg(input string name, input bit want_out_valid);
    int n = 0;
    @(negedge clock);
    while ((want_out_valid ? !out_valid : !res_valid) && n < 60) begin @(negedge clock); n++; end
    check(name, {63'd0, want_out_valid ? out_valid : res_valid}, 64'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    int a0;
    vecs[0]  = mk("div_neg",    0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    vecs[1]  = mk("rem_neg",    1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    vecs[2]  = mk("divu",       0, 1, 0, 64'd100, 64'd7, 64'd14);
    vecs[3]  = mk("remu",       1, 1, 0, 64'd100, 64'd7, 64'd2);
    vecs[4]  = mk("remuw",      1, 1, 1, 64'hFFFF_FFFF_0000_0007, 64'd3, 64'd1);
    vecs[5]  = mk("divw_ovf",   0, 0, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    vecs[6]  = mk("rem_zero",   1, 0, 0, 64'h1234, 64'd0, 64'h1234);
    vecs[7]  = mk("div_zero",   0, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    vecs[8]  = mk("divw_neg",   0, 0, 1, 64'h1234_5678_FFFF_FFF0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC);
    vecs[9]  = mk("remw_ovf",   1, 0, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    vecs[10] = mk("div_ovf",    0, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    vecs[11] = mk("divuw",      0, 1, 1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF);
    vecs[12] = mk("remw_neg",   1, 0, 1, 64'h0000_0000_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF);
    vecs[13] = mk("divuw_zero", 0, 1, 1, 64'h55, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    vecs[14] = mk("remuw_zero", 1, 1, 1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001);

    // reset values
    repeat (2) @(posedge clock); #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_div_valid", {63'd0, div_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_res_data", res_data, 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // DIV -7/2: issue timing and out_valid -> res_valid latency
    send(vecs[0], 1'b1);
    @(negedge clock);
    check("issue_div_valid", {63'd0, div_valid}, 64'd1);
    check("issue_div_signed", {63'd0, div_signed}, 64'd1);
    check("issue_divw", {63'd0, divw}, 64'd0);
    check("issue_dividend", dividend, vecs[0].a);
    wait_neg("out_valid_seen", 1'b1);
    check("res_valid_not_yet", {63'd0, res_valid}, 64'd0);
    @(negedge clock);
    check("res_valid_after_out", {63'd0, res_valid}, 64'd1);
    wait_drain();

    // REMUW request signals
    send(vecs[4], 1'b1);
    @(negedge clock);
    check("remuw_divw", {63'd0, divw}, 64'd1);
    check("remuw_div_signed", {63'd0, div_signed}, 64'd0);
    wait_drain();

    // table, random divider latency
    for (int i = 0; i < NV; i++) begin
      lat = $urandom_range(1, 6);
      send(vecs[i], 1'b1);
      wait_drain();
    end

    // back-to-back random picks
    for (int k = 0; k < 8; k++) begin
      lat = $urandom_range(1, 4);
      send(vecs[$urandom_range(0, NV - 1)], 1'b1);
    end
    wait_drain();
    lat = 3;

    // special cases: fast path skips the divider
    for (int k = 5; k <= 6; k++) begin
      a0 = accepts;
      send(vecs[k], 1'b1);
      @(negedge clock);
`ifdef YSYX_22050854_DIV_FASTPATH_EN
      check("fast_res_valid", {63'd0, res_valid}, 64'd1);
      check("fast_no_div_valid", {63'd0, div_valid}, 64'd0);
      wait_drain();
      check("fast_accepts", 64'(accepts - a0), 64'd0);
`else
      check("slow_div_valid", {63'd0, div_valid}, 64'd1);
      wait_drain();
      check("slow_accepts", 64'(accepts - a0), 64'd1);
`endif
    end

    // div_ready stall keeps div_valid high, then exactly one accept
    a0 = accepts;
    div_ready = 1'b0;
    send(vecs[2], 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("stall_div_valid", {63'd0, div_valid}, 64'd1);
    end
    @(posedge clock); #1 div_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("post_accept_div_valid", {63'd0, div_valid}, 64'd0);
    @(posedge clock); #1;
    wait_drain();
    check("stall_accepts", 64'(accepts - a0), 64'd1);

    // res_ready low for 10 cycles in DONE
    res_ready = 1'b0;
    send(vecs[3], 1'b1);
    wait_neg("hold_res_valid", 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("hold_res_data", res_data, 64'd2);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_res_valid_hi", {63'd0, res_valid}, 64'd1);
    end
    @(posedge clock); #1 res_ready = 1'b1;
    wait_drain();

    // flush in IDLE drops the same-cycle request
    a0 = accepts;
    drive_op(vecs[0]);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    check("idle_flush_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clock);
    check("idle_flush_accepts", 64'(accepts - a0), 64'd0);
    @(posedge clock); #1;

    // flush in ISSUE without div_ready returns to IDLE
    a0 = accepts;
    div_ready = 1'b0;
    send(vecs[2], 1'b0);
    flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0; div_ready = 1'b1;
    check("issue_flush_idle", {63'd0, in_ready}, 64'd1);
    check("issue_flush_accepts", 64'(accepts - a0), 64'd0);

    // flush 5 cycles into WAIT, new op waits for the stale out_valid
    lat = 12;
    send(vecs[2], 1'b0);
    repeat (6) @(posedge clock);
    #1 flush = 1'b1;
    drive_op(vecs[0]);
    in_valid = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    lat = 3;
    begin
      int n = 0;
      @(negedge clock);
      while (!out_valid && n < 40) begin
        check("drain_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clock); n++;
      end
    end
    check("stale_out_valid", {63'd0, out_valid}, 64'd1);
    check("drain_in_ready_last", {63'd0, in_ready}, 64'd0);
    @(posedge clock); #1;
    check("post_drain_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.push_back(vecs[0].exp);
    @(posedge clock); #1 in_valid = 1'b0;
    wait_drain();

    // flush in DONE drops res_valid
    res_ready = 1'b0;
    send(vecs[3], 1'b0);
    wait_neg("done_res_valid", 1'b0);
    @(posedge clock); #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    check("done_flush_res_valid", {63'd0, res_valid}, 64'd0);
    check("done_flush_in_ready", {63'd0, in_ready}, 64'd1);
    res_ready = 1'b1;

    // asynchronous reset mid-WAIT
    lat = 12;
    send(vecs[1], 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_div_valid", {63'd0, div_valid}, 64'd0);
    check("arst_res_valid", {63'd0, res_valid}, 64'd0);
    check("arst_res_data", res_data, 64'd0);
    @(posedge clock); #1 reset = 1'b1;
    lat = 3;
    send(vecs[8], 1'b1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050854_div_ctrl.md
# ysyx_22050854_div_ctrl

Issue-side controller for the shared multi-cycle divider: accepts RV64M divide/remainder ops from the EXU, drives the divider's `div_valid`/`div_ready`/`out_valid` handshake, and returns a single selected, sign-corrected 64-bit result. It sits between EXU decode and the divider and stalls the pipeline through `busy`. With the fast path enabled, divide-by-zero and signed overflow are resolved locally without occupying the divider.

## Interface
- No parameters.
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: op request from EXU.
- `in_ready` out 1: controller can accept an op.
- `op_rem` in 1: 1 = REM*, 0 = DIV*.
- `op_unsigned` in 1: 1 = unsigned variant.
- `op_w` in 1: 1 = *W variant (32-bit).
- `src1` in 64: dividend.
- `src2` in 64: divisor.
- `flush` in 1: kill the in-flight op.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 64: final result.
- `busy` out 1: op in flight (state ≠ IDLE).
- `div_valid`, `divw`, `div_signed` out 1 each: divider request.
- `dividend`, `divisor` out 64 each: divider operands.
- `div_ready`, `out_valid` in 1 each: divider status.
- `quotient`, `remainder` in 64 each: divider results.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN.
- Reset: state IDLE, all output registers 0. Resulting outputs: `in_ready`=1, `res_valid`=0, `div_valid`=0, `busy`=0, `res_data`=0.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch the op and operands.
  - Special case with fast path enabled: go to DONE.
  - Otherwise: go to ISSUE.
- ISSUE:
  - Drive `div_valid`=1, `divw`=`op_w`, `div_signed`=~`op_unsigned`, and the latched operands.
  - On `div_ready` go to WAIT. `div_valid` is low from the next cycle.
- WAIT:
  - On `out_valid`, capture `op_rem` ? `remainder` : `quotient`.
  - Go to DONE.
- DONE:
  - `res_valid`=1 with `res_data` held stable.
  - On `res_ready` go to IDLE.
- DRAIN:
  - Discard the next `out_valid`, then go to IDLE.
  - `in_ready`=0.
- W ops:
  - Only the low 32 bits of the sources are meaningful.
  - The controller always rebuilds the result as sext(result[31:0]) and does not trust the upper 32 bits from the divider.
- Fast-path special cases (64-bit; W ops use the low 32 bits, then sext):
  - Divisor 0: DIV/DIVU returns all ones; REM/REMU returns the dividend.
  - Signed overflow (INT_MIN / −1): DIV returns the dividend; REM returns 0.
- Flush (priority over every other event):
  - IDLE: drop a same-cycle `in_valid`.
  - ISSUE: if `div_ready` is 0 that cycle, go to IDLE. If `div_ready` is 1, the op was accepted, so go to DRAIN.
  - WAIT: go to DRAIN, or to IDLE if `out_valid` is asserted the same cycle.
  - DONE: go to IDLE with `res_valid` low next cycle.
  - DRAIN: stay in DRAIN.
- Reset mid-operation returns to IDLE immediately.
  - The divider shares the reset, so no drain is needed.

## Timing
- Acceptance to `div_valid`: 1 cycle.
- `div_valid` stays high until the cycle `div_ready` is sampled high, and never for two accepted cycles.
- `out_valid` to `res_valid`: 1 cycle. `res_data` is registered.
- Fast path: `res_valid` is asserted in the cycle after acceptance.
- Back-to-back: a new op is accepted in the cycle after `res_valid && res_ready`. There is no IDLE bypass from DONE.
- `in_ready` and `res_valid` are never both 1.

## Configuration
- `YSYX_22050854_DIV_FASTPATH_EN` defined:
  - Special cases are detected in IDLE and complete via DONE with a 1-cycle latency.
  - The divider is not touched for these cases.
- Macro undefined:
  - Every op goes through ISSUE/WAIT.
  - Results for special cases are whatever the divider returns, then W sign-extension is applied.
  - The special-case logic is not instantiated.

## Structure
- Package `ysyx_22050854_div_pkg`:
  - State enum.
  - Constants `INT64_MIN`, `INT32_MIN`, `ALL_ONES64`.
  - Op-kind encoding `{op_rem, op_unsigned, op_w}`.
- Sub-module `ysyx_22050854_div_special`:
  - Combinational; takes the op and operands.
  - Outputs `is_special` and `special_res`.
  - Instantiated only under the macro.
- FSM, latches and result selection live in the top module.

## Test plan
- DIV 64 signed, src1=−7, src2=2 → `div_valid` one cycle, divider accepted, then `res_data`=0xFFFFFFFFFFFFFFFD (−3), `res_valid` 1 cycle after `out_valid`.
- REMUW, src1=0xFFFFFFFF_00000007, src2=3 → `divw`=1, `div_signed`=0, `res_data`=0x0000000000000001.
- DIVW, src1=0x80000000, src2=0xFFFFFFFF, with fast path → no `div_valid`, `res_valid` next cycle, `res_data`=0xFFFFFFFF80000000.
- REM, src2=0, src1=0x1234, with fast path → `res_data`=0x1234. Without the macro → `div_valid` is issued.
- Flush asserted 5 cycles into WAIT, new op presented → `in_ready`=0 until the stale `out_valid` is drained. The next op's result is not corrupted.
- `res_ready` held low for 10 cycles in DONE → `res_data` stable, `in_ready`=0. Reset (low) mid-WAIT → outputs return to their reset values asynchronously.
